fetch_pc_predictor: RTL and testbench
=====================================

Name: fetch_pc_predictor

Overview:
- Fetch-side counterpart of the EX-stage branch resolution unit.
- Owns the program counter and predicts branches with a direct-mapped BTB of 2-bit saturating counters.
- Consumes each branch outcome (taken flag, target) and jumps from ID; redirects fetch and issues pipeline flushes on misprediction.
- Sits in front of instruction memory and drives the IF/ID register.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2. IDX = log2(ENTRIES).
- RESET_PC, 32'h0000_0000, first fetch address; word aligned.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall from ID; hold PC
- fetch_pc  out  32  address presented to instruction memory
- fetch_valid  out  1  fetch_pc is a real fetch
- pred_taken  out  1  prediction for fetch_pc; carried down pipeline
- pred_target  out  32  predicted target for fetch_pc; carried down pipeline
- jump_valid  in  1  ID decoded an unconditional jump
- jump_target  in  32  jump destination
- resolve_valid  in  1  EX resolved a branch this cycle
- resolve_pc  in  32  PC of the resolved branch
- resolve_taken  in  1  actual outcome (EX zero flag)
- resolve_target  in  32  computed branch address
- resolve_pred_taken  in  1  prediction that travelled with the branch
- resolve_pred_target  in  32  predicted target that travelled with the branch
- flush_id  out  1  clear IF/ID this edge
- flush_ex  out  1  clear IF/ID and ID/EX this edge
- mispredict_count  out  16  saturating mispredict counter

Behaviour:
- Reset (async, rst_n low):
  - fetch_pc = RESET_PC; fetch_valid = 0; mispredict_count = 0.
  - FSM enters HOLD.
  - All BTB valid bits = 0; all counters = 2'b01.
- FSM:
  - HOLD: fetch_valid = 0 and PC is unchanged. Moves to RUN on the first edge after rst_n deasserts.
  - RUN: fetch_valid = 1 and stays in RUN.
  - Reset mid-operation returns to HOLD immediately.
- BTB lookup (combinational on fetch_pc):
  - index = fetch_pc[IDX+1:2]; tag = fetch_pc[31:IDX+2].
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1]; pred_target = entry target on hit, else 0.
  - In HOLD, pred_taken = 0.
- Mispredict (combinational):
  - mispredict = resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target != resolve_pred_target)).
  - Correct address = resolve_taken ? resolve_target : resolve_pc + 4.
- Next-PC priority (RUN, registered on the edge):
  1. mispredict: PC = correct address.
  2. jump_valid: PC = jump_target.
  3. stall: PC held.
  4. pred_taken: PC = pred_target.
  5. Otherwise PC = PC + 4.
- Redirect rules:
  - A redirect (items 1 or 2) overrides stall.
  - On a mispredict in the same cycle as jump_valid, the jump is discarded; it is younger and flushed.
- Alignment and arithmetic:
  - Bits [1:0] of every loaded PC are forced to 0.
  - PC + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Flushes (combinational, same cycle as the cause):
  - flush_ex = mispredict.
  - flush_id = jump_valid && !mispredict.
  - Both are 0 in HOLD and during reset.
- BTB update (at the edge when resolve_valid = 1, index and tag taken from resolve_pc):
  - Hit: counter saturating increment if taken, decrement if not taken (limits 0 and 3). If taken, target = resolve_target.
  - Miss and taken: allocate the entry, overwriting any occupant: valid = 1, tag, target, counter = 2'b10.
  - Miss and not taken: no change.
  - A lookup and an update to the same entry in the same cycle: the lookup sees the pre-update contents (no bypass).
- mispredict_count increments on every mispredict and saturates at 16'hFFFF.

Test Plan:
- Reset release, no branches -> one HOLD cycle with fetch_valid = 0, then fetch_pc = 0, 4, 8, C; pred_taken = 0 throughout.
- Resolve pc = 0x10, taken, target = 0x40, pred_taken = 0 -> flush_ex = 1; next fetch_pc = 0x40; entry allocated with ctr = 2; a later fetch at 0x10 gives pred_taken = 1, pred_target = 0x40; mispredict_count = 1.
- Same branch resolved not taken three times with matching predictions -> counter 2 -> 1 -> 0 with mispredicts only where predictions differ; the next fetch at 0x10 predicts not taken.
- stall = 1 with jump_valid = 1, target 0x200 -> fetch_pc = 0x200 next cycle; flush_id = 1; flush_ex = 0.
- mispredict and jump_valid in the same cycle -> PC = resolve target; flush_ex = 1; flush_id = 0; jump ignored.
- PC = 0xFFFF_FFFC, no prediction -> next PC = 0; assert rst_n low mid-run -> fetch_pc = RESET_PC and fetch_valid = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage program counter with a direct-mapped BTB of 2-bit counters.
// Redirects fetch and raises IF/ID or ID/EX flushes on jumps and branch mispredictions.
module fetch_pc_predictor #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [15:0] mispredict_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic   running;

  logic [31:0] pc_reg, pc_next;
  logic [15:0] count_reg;

  logic            btb_valid  [ENTRIES];
  logic [TAGW-1:0] btb_tag    [ENTRIES];
  logic [31:0]     btb_target [ENTRIES];
  logic [1:0]      btb_ctr    [ENTRIES];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HOLD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    running    = 1'b0;
    case (state_reg)
      HOLD: begin
        state_next = RUN;
      end
      RUN: begin
        running    = 1'b1;
        state_next = RUN;
      end
      default: state_next = HOLD;
    endcase
  end

  // ---------------- BTB lookup ----------------
  logic [IDX-1:0]  look_idx;
  logic [TAGW-1:0] look_tag;
  logic            look_hit;

  assign look_idx = pc_reg[IDX+1:2];
  assign look_tag = pc_reg[31:IDX+2];
  assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

  assign pred_taken  = running && look_hit && btb_ctr[look_idx][1];
  assign pred_target = look_hit ? btb_target[look_idx] : 32'h0;

  // ---------------- Mispredict detection ----------------
  logic        mispredict;
  logic [31:0] correct_pc;

  assign mispredict = running && resolve_valid &&
                      ((resolve_taken != resolve_pred_taken) ||
                       (resolve_taken && (resolve_target != resolve_pred_target)));
  assign correct_pc = resolve_taken ? resolve_target : (resolve_pc + 32'd4);

  assign flush_ex = mispredict;
  assign flush_id = running && jump_valid && !mispredict;

  // ---------------- Next PC ----------------
  always_comb begin
    pc_next = pc_reg;
    if (running) begin
      if (mispredict) begin
        pc_next = correct_pc;
      end else if (jump_valid) begin
        pc_next = jump_target;
      end else if (stall) begin
        pc_next = pc_reg;
      end else if (pred_taken) begin
        pc_next = pred_target;
      end else begin
        pc_next = pc_reg + 32'd4;
      end
    end
    pc_next = pc_next & ~32'h3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 16'h0;
    end else if (mispredict && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign fetch_pc         = pc_reg;
  assign fetch_valid      = running;
  assign mispredict_count = count_reg;

  // ---------------- BTB update ----------------
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  logic            upd_en;
  logic [1:0]      upd_ctr;
  logic [31:0]     upd_target;

  assign upd_idx = resolve_pc[IDX+1:2];
  assign upd_tag = resolve_pc[31:IDX+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  // A miss that was not taken leaves the table untouched.
  assign upd_en  = running && resolve_valid && (upd_hit || resolve_taken);

  always_comb begin
    upd_ctr    = 2'b10;
    upd_target = resolve_taken ? resolve_target : btb_target[upd_idx];
    if (upd_hit) begin
      upd_ctr = btb_ctr[upd_idx];
      if (resolve_taken && (btb_ctr[upd_idx] != 2'b11)) begin
        upd_ctr = btb_ctr[upd_idx] + 2'b01;
      end else if (!resolve_taken && (btb_ctr[upd_idx] != 2'b00)) begin
        upd_ctr = btb_ctr[upd_idx] - 2'b01;
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        btb_valid[gi]  <= 1'b0;
        btb_tag[gi]    <= '0;
        btb_target[gi] <= 32'h0;
        btb_ctr[gi]    <= 2'b01;
      end else if (upd_en && (upd_idx == IDX'(gi))) begin
        btb_valid[gi]  <= 1'b1;
        btb_tag[gi]    <= upd_tag;
        btb_target[gi] <= upd_target;
        btb_ctr[gi]    <= upd_ctr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_fetch_pc_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        flush_id;
  logic        flush_ex;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  fetch_pc_predictor #(.ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
    .flush_id(flush_id), .flush_ex(flush_ex), .mispredict_count(mispredict_count)
  );

  typedef struct {
    string       name;
    logic        fv;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        fid;
    logic        fex;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  event chk_now;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, got, want);
    end
  endtask

  // Monitor: drains expectations at each falling edge (or on demand for async events).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        e = q.pop_front();
        $display("txn %-12s fv=%0d pc=%h pt=%0d ptg=%h fid=%0d fex=%0d cnt=%0d",
                 e.name, fetch_valid, fetch_pc, pred_taken, pred_target, flush_id, flush_ex, mispredict_count);
        chk(e.name, "fetch_valid", 32'(fetch_valid), 32'(e.fv));
        chk(e.name, "fetch_pc", fetch_pc, e.pc);
        chk(e.name, "pred_taken", 32'(pred_taken), 32'(e.pt));
        chk(e.name, "pred_target", pred_target, e.ptg);
        chk(e.name, "flush_id", 32'(flush_id), 32'(e.fid));
        chk(e.name, "flush_ex", 32'(flush_ex), 32'(e.fex));
        chk(e.name, "count", 32'(mispredict_count), 32'(e.cnt));
      end
    end
  end

  task automatic expect_out(input string nm, input logic fv, input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptg, input logic fid, input logic fex, input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.fv = fv; e.pc = pc; e.pt = pt; e.ptg = ptg; e.fid = fid; e.fex = fex; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    stall = 1'b0; jump_valid = 1'b0; jump_target = 32'h0;
    resolve_valid = 1'b0; resolve_pc = 32'h0; resolve_taken = 1'b0;
    resolve_target = 32'h0; resolve_pred_taken = 1'b0; resolve_pred_target = 32'h0;
  endtask

  task automatic jump(input logic [31:0] t);
    jump_valid = 1'b1; jump_target = t;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                         input logic ptk, input logic [31:0] ptg);
    resolve_valid = 1'b1; resolve_pc = pc; resolve_taken = tk;
    resolve_target = tg; resolve_pred_taken = ptk; resolve_pred_target = ptg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; jump_valid = 1'b0; jump_target = 32'h0;
    resolve_valid = 1'b0; resolve_pc = 32'h0; resolve_taken = 1'b0;
    resolve_target = 32'h0; resolve_pred_taken = 1'b0; resolve_pred_target = 32'h0;

    // Flushes must stay low while reset is held, even with a jump present.
    cyc(); cyc();
    jump(32'h200);
    expect_out("reset", 0, 32'h0, 0, 32'h0, 0, 0, 16'd0);

    cyc();
    rst_n = 1'b1;
    expect_out("hold", 0, 32'h0, 0, 32'h0, 0, 0, 16'd0);
    cyc(); expect_out("seq0", 1, 32'h0, 0, 32'h0, 0, 0, 16'd0);
    cyc(); expect_out("seq4", 1, 32'h4, 0, 32'h0, 0, 0, 16'd0);
    cyc(); expect_out("seq8", 1, 32'h8, 0, 32'h0, 0, 0, 16'd0);
    cyc(); expect_out("seqC", 1, 32'hC, 0, 32'h0, 0, 0, 16'd0);

    // Taken branch predicted not-taken: allocate and redirect.
    cyc(); resolve(32'h10, 1, 32'h40, 0, 32'h0);
    expect_out("mis_alloc", 1, 32'h10, 0, 32'h0, 0, 1, 16'd0);
    cyc(); jump(32'h10);
    expect_out("redir40", 1, 32'h40, 0, 32'h0, 1, 0, 16'd1);
    cyc(); expect_out("predhit", 1, 32'h10, 1, 32'h40, 0, 0, 16'd1);

    // Not taken three times: 2 -> 1 -> 0 -> 0.
    cyc(); resolve(32'h10, 0, 32'h0, 1, 32'h40);
    expect_out("nt1_mis", 1, 32'h40, 0, 32'h0, 0, 1, 16'd1);
    cyc(); resolve(32'h10, 0, 32'h0, 0, 32'h0);
    expect_out("nt2_ok", 1, 32'h14, 0, 32'h0, 0, 0, 16'd2);
    cyc(); resolve(32'h10, 0, 32'h0, 0, 32'h0);
    expect_out("nt3_ok", 1, 32'h18, 0, 32'h0, 0, 0, 16'd2);
    cyc(); jump(32'h10);
    expect_out("jmp_back", 1, 32'h1C, 0, 32'h0, 1, 0, 16'd2);
    cyc(); expect_out("pred_nt", 1, 32'h10, 0, 32'h40, 0, 0, 16'd2);

    // Jump overrides stall.
    cyc(); stall = 1'b1; jump(32'h200);
    expect_out("stall_jmp", 1, 32'h14, 0, 32'h0, 1, 0, 16'd2);
    cyc(); stall = 1'b1;
    expect_out("stall_hold", 1, 32'h200, 0, 32'h0, 0, 0, 16'd2);

    // Target mismatch with simultaneous jump: jump is dropped.
    cyc(); resolve(32'h300, 1, 32'h500, 1, 32'h504); jump(32'h800);
    expect_out("mis_and_jmp", 1, 32'h200, 0, 32'h0, 0, 1, 16'd2);
    cyc(); jump(32'h303);
    expect_out("jmp_unalgn", 1, 32'h500, 0, 32'h0, 1, 0, 16'd3);
    cyc(); expect_out("align_hit", 1, 32'h300, 1, 32'h500, 0, 0, 16'd3);

    // PC wrap.
    cyc(); jump(32'hFFFF_FFFC);
    expect_out("jmp_top", 1, 32'h500, 0, 32'h0, 1, 0, 16'd3);
    cyc(); expect_out("pc_top", 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 16'd3);
    cyc(); expect_out("pc_wrap", 1, 32'h0, 0, 32'h0, 0, 0, 16'd3);

    // Asynchronous reset mid-cycle, observed before the next clock edge.
    cyc();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 32'h0, 0, 32'h0, 0, 0, 16'd0);
    -> chk_now;

    // BTB must be cleared by reset.
    cyc(); rst_n = 1'b1;
    expect_out("hold2", 0, 32'h0, 0, 32'h0, 0, 0, 16'd0);
    cyc(); jump(32'h300);
    expect_out("rerun", 1, 32'h0, 0, 32'h0, 1, 0, 16'd0);
    cyc(); expect_out("btb_clr", 1, 32'h300, 0, 32'h0, 0, 0, 16'd0);

    cyc(); cyc();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
